// File: rtl/sampler_pkg.sv
// Shared defaults for the periodic sampler: widths, reset period, minimum period, channel word type.
// The optional averaging mode is selected with the SAMPLER_AVG_EN macro.
package sampler_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 26;
    localparam int DEF_PERIOD = 25_000_000;
    localparam int MIN_PERIOD = 2;
    localparam int AVG_SHIFT  = 2;

    typedef logic [DATA_W-1:0] ch_word_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Programmable period divider: counts 0..period_q-1 and emits a registered one-cycle tick per wrap.
module sample_tick_gen
    import sampler_pkg::*;
#(
    parameter int CNT_W      = sampler_pkg::CNT_W,
    parameter int DEF_PERIOD = sampler_pkg::DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic             period_load,
    output logic             sample_tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_clamped;
    logic             at_wrap;

    assign period_clamped = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
    assign at_wrap        = (cnt == period_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_q    <= CNT_W'(DEF_PERIOD);
            sample_tick <= 1'b0;
        end else begin
            if (period_load) begin
                period_q <= period_clamped;
            end
            // A load restarts the count and suppresses the wrap tick of the same cycle.
            if (!enable || period_load || at_wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            sample_tick <= enable && !period_load && at_wrap;
        end
    end

endmodule

// File: rtl/periodic_sampler.sv
// Multi-channel periodic sampler: captures enabled channels on each tick, offers them on valid/ready.
// Define SAMPLER_AVG_EN to average 2**AVG_SHIFT ticks per output sample.
module periodic_sampler
    import sampler_pkg::*;
#(
    parameter int DATA_W     = sampler_pkg::DATA_W,
    parameter int NUM_CH     = sampler_pkg::NUM_CH,
    parameter int CNT_W      = sampler_pkg::CNT_W,
`ifdef SAMPLER_AVG_EN
    parameter int AVG_SHIFT  = sampler_pkg::AVG_SHIFT,
`endif
    parameter int DEF_PERIOD = sampler_pkg::DEF_PERIOD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         period,
    input  logic                     period_load,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic                     sample_tick,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    logic                     tick;
    logic                     sample_evt;
    logic [NUM_CH*DATA_W-1:0] data_nxt;

    sample_tick_gen #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period      (period),
        .period_load (period_load),
        .sample_tick (tick)
    );

    assign sample_tick = tick;

`ifdef SAMPLER_AVG_EN
    localparam int ACC_W = DATA_W + AVG_SHIFT;
    localparam int WIN_W = AVG_SHIFT + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_SHIFT) - 1);

    logic [ACC_W-1:0] acc_q   [NUM_CH];
    logic [ACC_W-1:0] acc_sum [NUM_CH];
    logic [WIN_W-1:0] win_q;
    logic             avg_clr;

    assign avg_clr    = period_load | ~enable;
    assign sample_evt = tick & ~avg_clr & (win_q == WIN_LAST);

    always_comb begin
        data_nxt = data_out;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_sum[c] = acc_q[c] + ACC_W'(data_in[c*DATA_W +: DATA_W]);
            if (ch_mask[c]) begin
                data_nxt[c*DATA_W +: DATA_W] = DATA_W'(acc_sum[c] >> AVG_SHIFT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else if (avg_clr || (tick && win_q == WIN_LAST)) begin
            win_q <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else if (tick) begin
            win_q <= win_q + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_mask[c]) acc_q[c] <= acc_sum[c];
            end
        end
    end
`else
    assign sample_evt = tick;

    always_comb begin
        data_nxt = data_out;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_mask[c]) data_nxt[c*DATA_W +: DATA_W] = data_in[c*DATA_W +: DATA_W];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (sample_evt) begin
                data_out  <= data_nxt;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A new overrun event takes priority over a clear in the same cycle.
            if (sample_evt && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
